word_packer: RTL and testbench

WORD_PACKER -- requirements
Module: word_packer

---
 rtl/word_packer.sv | 103 ++++++++++
 tb/tb_word_packer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_packer.sv
// Packs LANES narrow words into one wide beat; a flush emits a partial beat.
// A two-state FILL/HOLD FSM keeps input and output phases strictly separate.
module word_packer #(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    localparam int CW = $clog2(LANES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    input  logic                   flush,
    output logic                   out_valid,
    output logic [WIDTH*LANES-1:0] out_data,
    output logic [CW-1:0]          out_count,
    input  logic                   out_ready,
    output logic [15:0]            beats_sent
);

    localparam int IW = $clog2(LANES);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e                        state_q, state_d;
    logic [IW-1:0]                 idx_q, idx_d;
    logic [LANES-1:0][WIDTH-1:0]   lane_q, lane_d;
    logic [CW-1:0]                 count_q, count_d;
    logic [15:0]                   beats_q, beats_d;
    logic                          accept;

    assign in_ready   = (state_q == FILL);
    assign out_valid  = (state_q == HOLD);
    assign out_count  = count_q;
    assign beats_sent = beats_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        count_d = count_q;
        beats_d = beats_q;
        accept  = in_valid && (state_q == FILL);
        case (state_q)
            FILL: begin
                if (accept) begin
                    lane_d[idx_q] = in_data;
                    // A flush on the word that fills the last lane still yields one beat.
                    if ((idx_q == IW'(LANES - 1)) || flush) begin
                        state_d = HOLD;
                        count_d = CW'(idx_q) + CW'(1);
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else if (flush && (idx_q != '0)) begin
                    state_d = HOLD;
                    count_d = CW'(idx_q);
                    idx_d   = '0;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = FILL;
                    lane_d  = '0;
                    count_d = '0;
                    beats_d = beats_q + 16'd1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Lanes at or above out_count (all of them while filling) read as zero.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (CW'(i) < count_q) begin
                out_data[i*WIDTH +: WIDTH] = lane_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= '0;
            lane_q  <= '0;
            count_q <= '0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            count_q <= count_d;
            beats_q <= beats_d;
        end
    end

endmodule

// File: tb/tb_word_packer.sv
// Bench for word_packer (WIDTH=8, LANES=4): directed scenarios plus random
// traffic against a queue-based model of which words form each beat.
module tb_word_packer;

    localparam int W = 8;
    localparam int L = 4;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic           in_ready;
    logic           flush;
    logic           out_valid;
    logic [W*L-1:0] out_data;
    logic [2:0]     out_count;
    logic           out_ready;
    logic [15:0]    beats_sent;

    word_packer #(.WIDTH(W), .LANES(L)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_count  (out_count),
        .out_ready  (out_ready),
        .beats_sent (beats_sent)
    );

    // Clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: pending words wait in exp_q; a complete or flushed group becomes the held beat.
    logic [W-1:0]   exp_q[$];
    logic           m_hold;
    logic [W*L-1:0] m_data;
    int             m_cnt;
    logic [15:0]    m_beats;
    logic [W*L-1:0] exp_data;
    logic [2:0]     exp_cnt;

    int errors = 0;
    int checks = 0;

    task automatic model_reset();
        exp_q.delete();
        m_hold   = 1'b0;
        m_data   = '0;
        m_cnt    = 0;
        m_beats  = 16'd0;
        exp_data = '0;
        exp_cnt  = 3'd0;
    endtask

    task automatic model_expect();
        exp_cnt  = m_hold ? 3'(m_cnt) : 3'd0;
        exp_data = m_hold ? m_data : '0;
    endtask

    // Driver: inputs change at negedge, model advances for the coming posedge,
    // and the task returns 1 time unit after that posedge.
    task automatic drive(input logic v, input logic [W-1:0] d, input logic f, input logic r);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = r;
        if (!m_hold) begin
            if (v) exp_q.push_back(d);
            if (exp_q.size() == L || (f && exp_q.size() > 0)) begin
                m_data = '0;
                for (int i = 0; i < exp_q.size(); i++) m_data[i*W +: W] = exp_q[i];
                m_cnt  = exp_q.size();
                exp_q.delete();
                m_hold = 1'b1;
            end
        end else if (r) begin
            m_hold  = 1'b0;
            m_beats = m_beats + 16'd1;
        end
        model_expect();
        @(posedge clk);
        #1;
    endtask

    task automatic assert_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
    endtask

    // Release at a negedge with inputs already presented, so the very next posedge may accept.
    task automatic release_reset(input logic v, input logic [W-1:0] d);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        flush     = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        if (v) exp_q.push_back(d);
        model_expect();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== 3'd0 ||
            out_data !== '0 || beats_sent !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b ready=%b cnt=%0d data=%h beats=%0d, want 0 1 0 0 0",
                     out_valid, in_ready, out_count, out_data, beats_sent);
        end
        release_reset(1'b0, '0);
    endtask

    task automatic test_full_beat();
        drive(1'b1, 8'h11, 1'b0, 1'b1);
        drive(1'b1, 8'h22, 1'b0, 1'b1);
        drive(1'b1, 8'h33, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL partial_fill_hidden: valid=%b data=%h, want 0 00000000", out_valid, out_data);
        end
        drive(1'b1, 8'h44, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_count !== 3'd4 || out_data !== 32'h44332211 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_beat: valid=%b cnt=%0d data=%h ready=%b, want 1 4 44332211 0",
                     out_valid, out_count, out_data, in_ready);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || beats_sent !== 16'd1 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL full_beat_done: valid=%b ready=%b beats=%0d data=%h, want 0 1 1 00000000",
                     out_valid, in_ready, beats_sent, out_data);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 8'hAA, 1'b0, 1'b0);
        drive(1'b1, 8'hBB, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_count !== 3'd2 || out_data !== 32'h0000BBAA) begin
            errors++;
            $display("FAIL flush_partial: valid=%b cnt=%0d data=%h, want 1 2 0000bbaa",
                     out_valid, out_count, out_data);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || beats_sent !== m_beats) begin
            errors++;
            $display("FAIL flush_done: valid=%b beats=%0d, want 0 %0d", out_valid, beats_sent, m_beats);
        end
    endtask

    task automatic test_flush_ignored();
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || beats_sent !== m_beats) begin
            errors++;
            $display("FAIL flush_empty: valid=%b beats=%0d, want 0 %0d", out_valid, beats_sent, m_beats);
        end
        for (int i = 0; i < L; i++) drive(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_count !== 3'd4 || out_data !== 32'hC3C2C1C0) begin
            errors++;
            $display("FAIL flush_in_hold: valid=%b cnt=%0d data=%h, want 1 4 c3c2c1c0",
                     out_valid, out_count, out_data);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || beats_sent !== m_beats) begin
            errors++;
            $display("FAIL flush_not_remembered: valid=%b beats=%0d, want 0 %0d",
                     out_valid, beats_sent, m_beats);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < L; i++) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_count !== exp_cnt || out_data !== exp_data) begin
                errors++;
                $display("FAIL backpressure_stable[%0d]: valid=%b ready=%b cnt=%0d data=%h, want 1 0 %0d %h",
                         c, out_valid, in_ready, out_count, out_data, exp_cnt, exp_data);
            end
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || beats_sent !== m_beats) begin
            errors++;
            $display("FAIL backpressure_release: valid=%b beats=%0d, want 0 %0d", out_valid, beats_sent, m_beats);
        end
    endtask

    task automatic test_flush_with_accept();
        logic [15:0] start_beats;
        drive(1'b1, 8'h01, 1'b0, 1'b0);
        drive(1'b1, 8'h02, 1'b0, 1'b0);
        drive(1'b1, 8'h03, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_count !== 3'd3 || out_data !== 32'h00030201) begin
            errors++;
            $display("FAIL flush_accept_3: valid=%b cnt=%0d data=%h, want 1 3 00030201",
                     out_valid, out_count, out_data);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        start_beats = m_beats;
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b1);
        drive(1'b1, 8'h44, 1'b1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_count !== 3'd4 || out_data !== 32'h44332211) begin
            errors++;
            $display("FAIL flush_accept_4: valid=%b cnt=%0d data=%h, want 1 4 44332211",
                     out_valid, out_count, out_data);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || beats_sent !== start_beats + 16'd1) begin
            errors++;
            $display("FAIL flush_accept_single: valid=%b beats=%0d, want 0 %0d",
                     out_valid, beats_sent, start_beats + 16'd1);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < L; i++) drive(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
        assert_reset();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== 3'd0 || out_data !== '0 || beats_sent !== 16'd0) begin
            errors++;
            $display("FAIL reset_in_hold: valid=%b ready=%b cnt=%0d data=%h beats=%0d, want 0 1 0 0 0",
                     out_valid, in_ready, out_count, out_data, beats_sent);
        end
        release_reset(1'b1, 8'h71);
        drive(1'b1, 8'h72, 1'b0, 1'b1);
        assert_reset();
        release_reset(1'b1, 8'h51);
        for (int i = 2; i <= L; i++) drive(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_count !== 3'd4 || out_data !== 32'h54535251 || beats_sent !== 16'd0) begin
            errors++;
            $display("FAIL reset_discard: valid=%b cnt=%0d data=%h beats=%0d, want 1 4 54535251 0",
                     out_valid, out_count, out_data, beats_sent);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
            checks++;
            if (out_valid !== m_hold || in_ready !== !m_hold || out_count !== exp_cnt ||
                out_data !== exp_data || beats_sent !== m_beats) begin
                errors++;
                $display("FAIL random[%0d]: valid=%b ready=%b cnt=%0d data=%h beats=%0d, want %b %b %0d %h %0d",
                         c, out_valid, in_ready, out_count, out_data, beats_sent,
                         m_hold, !m_hold, exp_cnt, exp_data, m_beats);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #1;
        test_reset();
        test_full_beat();
        test_flush();
        test_flush_ignored();
        test_backpressure();
        test_flush_with_accept();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
